// File: rtl/md_pkg.sv
// Shared decode constants and helpers for the multiply/divide scheduler.
// The D-stage hazard logic and the E-stage start logic use the same decoders.
package md_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    // Encoding matches func[1:0] of the four arithmetic ops.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_sel_e;

    function automatic logic is_md_start(input logic [5:0] op, input logic [5:0] func);
        return (op == OP_SPECIAL) &&
               (func inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    endfunction

    function automatic logic is_md_any(input logic [5:0] op, input logic [5:0] func);
        return (op == OP_SPECIAL) &&
               (func inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                             FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
    endfunction

    function automatic logic is_fn(input logic [5:0] op, input logic [5:0] func,
                                   input logic [5:0] fn);
        return (op == OP_SPECIAL) && (func == fn);
    endfunction

    function automatic md_sel_e md_sel(input logic [5:0] func);
        return md_sel_e'(func[1:0]);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply / divide producing the {hi,lo} pair.
// Division by zero returns the current {hi,lo} so a commit leaves them unchanged.
module md_arith
    import md_pkg::*;
(
    input  md_sel_e     sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] cur,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        neg_q;
    logic        neg_r;

    always_comb begin
        // Low 64 bits of a product of sign-extended operands equal the signed product.
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'b0, a} * {32'b0, b};

        // Signed division works on magnitudes; 0x80000000 / -1 then yields 0x80000000, rem 0.
        div_signed = (sel == MD_DIV);
        a_mag = (div_signed && a[31]) ? -a : a;
        b_mag = (div_signed && b[31]) ? -b : b;
        q_mag = '0;
        r_mag = '0;
        if (b != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        neg_q = div_signed && (a[31] ^ b[31]);
        neg_r = div_signed && a[31];

        case (sel)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            default: begin
                if (b == '0) begin
                    result = cur;
                end else begin
                    result = {(neg_r ? -r_mag : r_mag), (neg_q ? -q_mag : q_mag)};
                end
            end
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, counts busy cycles of an in-flight
// operation and stalls D-stage HI/LO instructions until results are visible.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  e_op,
    input  logic [5:0]  e_func,
    input  logic [31:0] e_rs_val,
    input  logic [31:0] e_rt_val,
    input  logic [5:0]  d_op,
    input  logic [5:0]  d_func,
    output logic        busy,
    output logic        stall_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] count;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          e_start;
    logic          e_mthi;
    logic          e_mtlo;
    logic          e_mfhi;
    logic          e_mflo;
    md_sel_e       e_sel;
    logic [63:0]   arith_result;

    assign e_start = is_md_start(e_op, e_func);
    assign e_mthi  = is_fn(e_op, e_func, FN_MTHI);
    assign e_mtlo  = is_fn(e_op, e_func, FN_MTLO);
    assign e_mfhi  = is_fn(e_op, e_func, FN_MFHI);
    assign e_mflo  = is_fn(e_op, e_func, FN_MFLO);
    assign e_sel   = md_sel(e_func);

    md_arith u_arith (
        .sel    (e_sel),
        .a      (e_rs_val),
        .b      (e_rt_val),
        .cur    ({hi, lo}),
        .result (arith_result)
    );

    assign busy    = (count != '0);
    // e_start covers the instruction directly behind a start, before busy rises.
    assign stall_d = is_md_any(d_op, d_func) && (busy || e_start);

    always_comb begin
        md_rdata = '0;
        if (e_mfhi) begin
            md_rdata = hi;
        end else if (e_mflo) begin
            md_rdata = lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            if (count != '0) begin
                count <= count - CW'(1);
                if (count == CW'(1)) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
            // A start on the completion edge commits the old result, then reloads.
            if (e_start) begin
                pend_hi <= arith_result[63:32];
                pend_lo <= arith_result[31:0];
                count   <= (e_sel == MD_MULT || e_sel == MD_MULTU) ? CW'(MULT_CYCLES)
                                                                   : CW'(DIV_CYCLES);
            end else begin
                if (e_mthi) begin
                    hi <= e_rs_val;
                end
                if (e_mtlo) begin
                    lo <= e_rs_val;
                end
            end
        end
    end

endmodule
